// File: rtl/sobel_edge_stage.sv
// Streaming Sobel edge stage between the CCD capture path and its output FIFO.
// Two-cycle pipeline: window/line-buffer capture, then gradient magnitude and output select.
module sobel_edge_stage #(
   parameter int INPUT_WIDTH  = 800,
   parameter int INPUT_HEIGHT = 480
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        iSOF,
   input  logic        iDVAL,
   input  logic [29:0] iPIXEL,
   input  logic        iMODE,
   input  logic        iFULL,
   output logic [29:0] oPIXEL,
   output logic        oDVAL,
   output logic        oEOF,
   output logic        oDROP,
   output logic        oFRAME_ERR
);

   localparam int DATA_W = 10;
   localparam int GRAD_W = 14;
   localparam int COL_W  = $clog2(INPUT_WIDTH);
   localparam int ROW_W  = $clog2(INPUT_HEIGHT);

   typedef enum logic [1:0] {WAIT_SOF, ACTIVE, DONE} state_t;

   state_t state, state_nxt;

   logic [COL_W-1:0]  col_cnt, cur_col;
   logic [ROW_W-1:0]  row_cnt, cur_row;
   logic              mode_reg;
   logic              accept, last_pix;
   logic [DATA_W-1:0] y;

   logic [DATA_W-1:0] lb_a [INPUT_WIDTH];
   logic [DATA_W-1:0] lb_b [INPUT_WIDTH];

   logic [DATA_W-1:0] win_p0 [3][3];
   logic              vld_p0, mask_p0, eof_p0, mode_p0;
   logic [29:0]       pix_p0;

   logic signed [GRAD_W-1:0] gx, gy;
   logic [GRAD_W:0]          m_sum;
   logic [DATA_W-1:0]        m;

   function automatic logic [DATA_W-1:0] gray(input logic [29:0] p);
      logic [11:0] s;
      s = {2'b00, p[29:20]} + {2'b00, p[19:10]} + {2'b00, p[9:0]};
      return DATA_W'(s / 12'd3);
   endfunction

   function automatic logic signed [GRAD_W-1:0] tap(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b,
                                                    input logic [DATA_W-1:0] c);
      return $signed({4'b0000, a}) + $signed({3'b000, b, 1'b0}) + $signed({4'b0000, c});
   endfunction

   function automatic logic [GRAD_W-1:0] mag(input logic signed [GRAD_W-1:0] v);
      return v[GRAD_W-1] ? $unsigned(-v) : $unsigned(v);
   endfunction

   function automatic logic [DATA_W-1:0] sat(input logic [GRAD_W:0] s);
      return (|s[GRAD_W:DATA_W]) ? {DATA_W{1'b1}} : s[DATA_W-1:0];
   endfunction

   // A start-of-frame pixel is always (0,0), whatever the counters held.
   assign accept   = iDVAL && (iSOF || state == ACTIVE);
   assign cur_col  = iSOF ? '0 : col_cnt;
   assign cur_row  = iSOF ? '0 : row_cnt;
   assign last_pix = (cur_row == ROW_W'(INPUT_HEIGHT - 1)) && (cur_col == COL_W'(INPUT_WIDTH - 1));
   assign y        = gray(iPIXEL);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= WAIT_SOF;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (iSOF)                state_nxt = ACTIVE;
      if (accept && last_pix)  state_nxt = DONE;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         col_cnt  <= '0;
         row_cnt  <= '0;
         mode_reg <= 1'b0;
      end else begin
         if (accept) begin
            if (cur_col == COL_W'(INPUT_WIDTH - 1)) begin
               col_cnt <= '0;
               row_cnt <= cur_row + ROW_W'(1);
            end else begin
               col_cnt <= cur_col + COL_W'(1);
               row_cnt <= cur_row;
            end
         end else if (iSOF) begin
            col_cnt <= '0;
            row_cnt <= '0;
         end
         if (iSOF) mode_reg <= iMODE;
      end
   end

   // Line buffers hold gray values of the two previous lines; rows 0-1 are masked so no reset.
   always_ff @(posedge CLK) begin
      if (accept) begin
         lb_a[cur_col] <= y;
         lb_b[cur_col] <= lb_a[cur_col];
      end
   end

   // Stage p0: shift the 3x3 window and capture per-pixel control
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               win_p0[i][j] <= '0;
         vld_p0  <= 1'b0;
         mask_p0 <= 1'b0;
         eof_p0  <= 1'b0;
         mode_p0 <= 1'b0;
         pix_p0  <= '0;
      end else begin
         vld_p0 <= accept;
         eof_p0 <= accept && last_pix;
         if (accept) begin
            for (int i = 0; i < 3; i++) begin
               win_p0[i][0] <= win_p0[i][1];
               win_p0[i][1] <= win_p0[i][2];
            end
            win_p0[0][2] <= lb_b[cur_col];
            win_p0[1][2] <= lb_a[cur_col];
            win_p0[2][2] <= y;
            mask_p0 <= (cur_row < ROW_W'(2)) || (cur_col < COL_W'(2));
            mode_p0 <= iSOF ? iMODE : mode_reg;
            pix_p0  <= iPIXEL;
         end
      end
   end

   assign gx    = tap(win_p0[0][2], win_p0[1][2], win_p0[2][2])
                - tap(win_p0[0][0], win_p0[1][0], win_p0[2][0]);
   assign gy    = tap(win_p0[2][0], win_p0[2][1], win_p0[2][2])
                - tap(win_p0[0][0], win_p0[0][1], win_p0[0][2]);
   assign m_sum = {1'b0, mag(gx)} + {1'b0, mag(gy)};
   assign m     = sat(m_sum);

   // Stage p1: registered output and status flags
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         oPIXEL     <= '0;
         oDVAL      <= 1'b0;
         oEOF       <= 1'b0;
         oDROP      <= 1'b0;
         oFRAME_ERR <= 1'b0;
      end else begin
         oDVAL      <= vld_p0;
         oEOF       <= vld_p0 && eof_p0;
         oFRAME_ERR <= iSOF && (state == ACTIVE);
         if (oDVAL && iFULL) oDROP <= 1'b1;
         else if (iSOF)      oDROP <= 1'b0;
         if (vld_p0) begin
            if (!mode_p0)     oPIXEL <= pix_p0;
            else if (mask_p0) oPIXEL <= '0;
            else              oPIXEL <= {m, m, m};
         end
      end
   end

endmodule

// File: doc/sobel_edge_stage.md
SOBEL_EDGE_STAGE -- requirements
Module: sobel_edge_stage

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 800, giving active pixels per line.
REQ-002 SHALL have parameter INPUT_HEIGHT, default 480, giving active lines per frame.
REQ-003 CLK  input  1  single clock; all logic on its rising edge; same domain as the CCD FIFO write clock.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 iSOF  input  1  start-of-frame pulse, one cycle.
REQ-006 iDVAL  input  1  input pixel valid.
REQ-007 iPIXEL  input  30  raw pixel {R[29:20],G[19:10],B[9:0]}.
REQ-008 iMODE  input  1  1 = edge detect, 0 = bypass; driven from iSW[17].
REQ-009 iFULL  input  1  downstream CCD FIFO full flag.
REQ-010 oPIXEL  output  30  output pixel; feeds the CCD FIFO data input.
REQ-011 oDVAL  output  1  output valid; feeds the CCD FIFO write request.
REQ-012 oEOF  output  1  one-cycle pulse with the last output pixel of a frame.
REQ-013 oDROP  output  1  sticky flag: an output was issued while iFULL was high.
REQ-014 oFRAME_ERR  output  1  one-cycle pulse when iSOF arrives mid-frame.

Function
REQ-015 States SHALL be WAIT_SOF, ACTIVE, DONE; reset enters WAIT_SOF.
REQ-016 WAIT_SOF or DONE, iSOF=1 -> ACTIVE: column and row counters cleared, iMODE latched into the frame mode register, oDROP cleared.
REQ-017 iDVAL while in WAIT_SOF or DONE SHALL be ignored: no counter change, no output.
REQ-018 iSOF and iDVAL in the same cycle: that pixel SHALL be accepted as (row 0, col 0).
REQ-019 In ACTIVE, each iDVAL SHALL advance the column counter 0..INPUT_WIDTH-1; wrap to 0 increments the row counter.
REQ-020 Acceptance of pixel (INPUT_HEIGHT-1, INPUT_WIDTH-1) SHALL move ACTIVE -> DONE.
REQ-021 iSOF in ACTIVE SHALL pulse oFRAME_ERR, clear the counters, re-latch the mode, and stay in ACTIVE; pixels already in the pipeline still drain.
REQ-022 Gray value Y = floor((R+G+B)/3): 12-bit sum, 10-bit result (max 1023).
REQ-023 Two line buffers, each INPUT_WIDTH x 10 bits, SHALL hold Y of the previous two lines, addressed by the column counter.
REQ-024 A 3x3 window of Y SHALL shift on each accepted pixel; the bottom-right window element is the current pixel (r,c).
REQ-025 Gx = (right col - left col) weighted 1,2,1 top to bottom; Gy = (bottom row - top row) weighted 1,2,1 left to right; signed, 14 bits minimum.
REQ-026 Magnitude M = |Gx|+|Gy|, saturated to 1023.
REQ-027 Edge mode: oPIXEL = {M,M,M}; if r<2 or c<2, oPIXEL = 0. This places the output one pixel diagonally offset from the window centre, by design.
REQ-028 Bypass mode: oPIXEL = iPIXEL delayed by the same latency.
REQ-029 Latency: pixel accepted in cycle t -> oDVAL=1 with its result in cycle t+2, in both modes; exactly one output per accepted pixel.
REQ-030 The mode used for a pixel SHALL be the frame mode register; iMODE changes mid-frame SHALL have no effect until the next iSOF.
REQ-031 oEOF SHALL assert with the output of pixel (INPUT_HEIGHT-1, INPUT_WIDTH-1).
REQ-032 oDVAL=1 with iFULL=1: the pixel is still presented (the FIFO discards it), and oDROP SHALL set.
REQ-033 No input stall: iDVAL on consecutive cycles SHALL be accepted at full rate.

Reset
REQ-034 RESET=1 SHALL force: state WAIT_SOF, counters 0, window and pipeline registers 0, frame mode 0, oPIXEL=0, oDVAL=0, oEOF=0, oDROP=0, oFRAME_ERR=0.
REQ-035 Line buffer contents need not be reset; rows 0-1 are masked per REQ-027.
REQ-036 RESET mid-frame SHALL abort in-flight pixels; no oDVAL occurs until a new iSOF and pixel arrive.

Verification
REQ-037 Reset, iDVAL=1 with no iSOF for 100 cycles -> oDVAL stays 0, state WAIT_SOF.
REQ-038 iMODE=1, full frame of constant iPIXEL 30'h1FF7FDFF -> every output is 0; exactly 384000 oDVAL; oEOF on the last one.
REQ-039 iMODE=1, vertical step: cols<400 =0, cols>=400 R=G=B=1023 -> rows>=2: output at cols 400,401 = 30'h3FFFFFFF, all other outputs 0.
REQ-040 iMODE=1, step height 128 (R=G=B=128) -> output at col 400 = {512,512,512}; step 1023 with 2x weight (row step) -> saturates to 1023.
REQ-041 iMODE=0, pixel 30'h12345678 accepted in cycle t -> oPIXEL=30'h12345678 with oDVAL in cycle t+2; toggling iMODE mid-frame has no effect until the next iSOF.
REQ-042 iSOF at pixel 1000 -> oFRAME_ERR pulse, next pixel output as (0,0); iFULL=1 during a single output -> oDROP=1 until the next iSOF.
